// File: rtl/sd_cmd_sequencer_pkg.sv
// ============================================================================
// Module      : sd_cmd_sequencer_pkg
// Description : Shared constants, state encoding and frame helpers for the
//               SD command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_cmd_sequencer_pkg;

    // Slave register map
    localparam logic [2:0] ADR_TX_CMD = 3'd0;
    localparam logic [2:0] ADR_RX_CMD = 3'd1;
    localparam logic [2:0] ADR_STATUS = 3'd4;
    localparam logic [2:0] ADR_TIMER  = 3'd6;

    // Status register bit positions
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 1;

    // Response type codes and their byte counts
    localparam logic [1:0] RESP_NONE        = 2'd0;
    localparam logic [1:0] RESP_SHORT       = 2'd1;
    localparam logic [1:0] RESP_LONG        = 2'd2;
    localparam logic [4:0] RESP_SHORT_BYTES = 5'd6;
    localparam logic [4:0] RESP_LONG_BYTES  = 5'd17;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRC    = 3'd1,
        ST_TXPOLL = 3'd2,
        ST_TXWR   = 3'd3,
        ST_RXPOLL = 3'd4,
        ST_RXRD   = 3'd5,
        ST_TMRRD  = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_t;

    // Reserved type 3 behaves like a short response
    function automatic logic [4:0] resp_len(input logic [1:0] rt);
        return (rt == RESP_LONG) ? RESP_LONG_BYTES : RESP_SHORT_BYTES;
    endfunction

    // Byte n of the 6-byte command frame
    function automatic logic [7:0] frame_byte(input logic [5:0]  idx,
                                              input logic [31:0] arg,
                                              input logic [6:0]  crc,
                                              input logic [2:0]  n);
        case (n)
            3'd0:    return {2'b01, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            3'd5:    return {crc, 1'b1};
            default: return 8'h00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_cmd_sequencer_if.sv
// ============================================================================
// Module      : sd_cmd_sequencer_if
// Description : Register-bus connection between the sequencer (master) and
//               the SD controller FIFO slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sd_cmd_sequencer_if;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_write_n_o;
    logic       m_read_n_o;
    logic       m_chipselect_o;
    logic       m_waitrequest_i;

    modport master (
        output m_adr_o, m_dat_o, m_write_n_o, m_read_n_o, m_chipselect_o,
        input  m_dat_i, m_waitrequest_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_write_n_o, m_read_n_o, m_chipselect_o,
        output m_dat_i, m_waitrequest_i
    );
endinterface

`default_nettype wire

// File: rtl/sd_cmd_sequencer_crc7.sv
// ============================================================================
// Module      : sd_crc7_serial
// Description : Bit-serial CRC7 (x^7+x^3+1, zero seed), MSB-first input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_crc7_serial
    import sd_cmd_sequencer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       clr,
    input  wire logic       en,
    input  wire logic       din,
    output logic [6:0]      crc
);

    logic fb;
    assign fb = din ^ crc[6];

    // LFSR step per enabled cycle; clear has priority over shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       crc <= 7'h00;
        else if (clr)  crc <= 7'h00;
        else if (en)   crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

endmodule

`default_nettype wire

// File: rtl/sd_cmd_sequencer.sv
// ============================================================================
// Module      : sd_cmd_sequencer
// Description : Builds an SD command frame (with CRC7), pushes it into the
//               slave TX FIFO and drains the response from the RX FIFO.
//               Optional macro SD_SEQ_TIMER_CHK_EN adds a timer read after
//               every empty RX status read and aborts when it reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_cmd_sequencer
    import sd_cmd_sequencer_pkg::*;
#(
    parameter int POLL_LIMIT = 1024,
    parameter int POLL_CNT_W = 11
) (
    input  wire logic        wb_clk_i,
    input  wire logic        wb_rst_i,
    input  wire logic        cmd_start,
    input  wire logic [5:0]  cmd_index,
    input  wire logic [31:0] cmd_arg,
    input  wire logic [1:0]  resp_type,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       resp_byte,
    output logic             resp_valid,
    sd_cmd_sequencer_if.master bus
);

    seq_state_t            state, state_n;
    logic                  gap, gap_n;
    logic [5:0]            idx_q, idx_n;
    logic [31:0]           arg_q, arg_n;
    logic [1:0]            rtype_q, rtype_n;
    logic [5:0]            bit_cnt, bit_cnt_n;
    logic [4:0]            byte_cnt, byte_cnt_n;
    logic [POLL_CNT_W-1:0] poll_cnt, poll_cnt_n;
    logic                  err_q, err_n;
    logic [7:0]            resp_byte_q, resp_byte_n;
    logic                  resp_valid_q, resp_valid_n;

    logic                  crc_clr, crc_en, crc_din;
    logic [6:0]            crc;
    logic [39:0]           frame_bits;

    logic                  cs, wr_n, rd_n;
    logic [2:0]            adr;
    logic [7:0]            dat;
    logic                  poll_at_limit;

    assign frame_bits    = {2'b01, idx_q, arg_q};
    assign crc_din       = frame_bits[6'd39 - bit_cnt];
    assign poll_at_limit = (poll_cnt == POLL_CNT_W'(POLL_LIMIT - 1));

    sd_crc7_serial u_crc (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .clr (crc_clr),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc)
    );

    // State and datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= ST_IDLE;
            gap          <= 1'b0;
            idx_q        <= '0;
            arg_q        <= '0;
            rtype_q      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            poll_cnt     <= '0;
            err_q        <= 1'b0;
            resp_byte_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state        <= state_n;
            gap          <= gap_n;
            idx_q        <= idx_n;
            arg_q        <= arg_n;
            rtype_q      <= rtype_n;
            bit_cnt      <= bit_cnt_n;
            byte_cnt     <= byte_cnt_n;
            poll_cnt     <= poll_cnt_n;
            err_q        <= err_n;
            resp_byte_q  <= resp_byte_n;
            resp_valid_q <= resp_valid_n;
        end
    end

    // Next-state and bus drive; gap inserts the idle cycle after each access
    always_comb begin
        state_n      = state;
        gap_n        = gap;
        idx_n        = idx_q;
        arg_n        = arg_q;
        rtype_n      = rtype_q;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        poll_cnt_n   = poll_cnt;
        err_n        = err_q;
        resp_byte_n  = resp_byte_q;
        resp_valid_n = 1'b0;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;
        cs           = 1'b0;
        wr_n         = 1'b1;
        rd_n         = 1'b1;
        adr          = ADR_TX_CMD;
        dat          = 8'h00;

        case (state)
            ST_IDLE: begin
                if (cmd_start) begin
                    idx_n     = cmd_index;
                    arg_n     = cmd_arg;
                    rtype_n   = resp_type;
                    err_n     = 1'b0;
                    bit_cnt_n = '0;
                    gap_n     = 1'b0;
                    crc_clr   = 1'b1;
                    state_n   = ST_CRC;
                end
            end

            ST_CRC: begin
                crc_en    = 1'b1;
                bit_cnt_n = bit_cnt + 6'd1;
                if (bit_cnt == 6'd39) begin
                    byte_cnt_n = '0;
                    poll_cnt_n = '0;
                    state_n    = ST_TXPOLL;
                end
            end

            ST_TXPOLL: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else begin
                    cs   = 1'b1;
                    rd_n = 1'b0;
                    adr  = ADR_STATUS;
                    if (!bus.m_waitrequest_i) begin
                        gap_n = 1'b1;
                        if (bus.m_dat_i[STAT_TX_FULL]) begin
                            if (poll_at_limit) begin
                                err_n   = 1'b1;
                                state_n = ST_DONE;
                            end else begin
                                poll_cnt_n = poll_cnt + POLL_CNT_W'(1);
                            end
                        end else begin
                            poll_cnt_n = '0;
                            state_n    = ST_TXWR;
                        end
                    end
                end
            end

            ST_TXWR: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else begin
                    cs   = 1'b1;
                    wr_n = 1'b0;
                    adr  = ADR_TX_CMD;
                    dat  = frame_byte(idx_q, arg_q, crc, byte_cnt[2:0]);
                    if (!bus.m_waitrequest_i) begin
                        gap_n = 1'b1;
                        if (byte_cnt == 5'd5) begin
                            byte_cnt_n = '0;
                            state_n    = (rtype_q == RESP_NONE) ? ST_DONE : ST_RXPOLL;
                        end else begin
                            byte_cnt_n = byte_cnt + 5'd1;
                            state_n    = ST_TXPOLL;
                        end
                    end
                end
            end

            ST_RXPOLL: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else begin
                    cs   = 1'b1;
                    rd_n = 1'b0;
                    adr  = ADR_STATUS;
                    if (!bus.m_waitrequest_i) begin
                        gap_n = 1'b1;
                        if (bus.m_dat_i[STAT_RX_EMPTY]) begin
                            if (poll_at_limit) begin
                                err_n   = 1'b1;
                                state_n = ST_DONE;
                            end else begin
                                poll_cnt_n = poll_cnt + POLL_CNT_W'(1);
`ifdef SD_SEQ_TIMER_CHK_EN
                                state_n    = ST_TMRRD;
`endif
                            end
                        end else begin
                            poll_cnt_n = '0;
                            state_n    = ST_RXRD;
                        end
                    end
                end
            end

`ifdef SD_SEQ_TIMER_CHK_EN
            ST_TMRRD: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else begin
                    cs   = 1'b1;
                    rd_n = 1'b0;
                    adr  = ADR_TIMER;
                    if (!bus.m_waitrequest_i) begin
                        gap_n = 1'b1;
                        if (bus.m_dat_i == 8'h00) begin
                            err_n   = 1'b1;
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_RXPOLL;
                        end
                    end
                end
            end
`endif

            ST_RXRD: begin
                if (gap) begin
                    gap_n = 1'b0;
                end else begin
                    cs   = 1'b1;
                    rd_n = 1'b0;
                    adr  = ADR_RX_CMD;
                    if (!bus.m_waitrequest_i) begin
                        gap_n        = 1'b1;
                        resp_byte_n  = bus.m_dat_i;
                        resp_valid_n = 1'b1;
                        if (byte_cnt == resp_len(rtype_q) - 5'd1) begin
                            state_n = ST_DONE;
                        end else begin
                            byte_cnt_n = byte_cnt + 5'd1;
                            state_n    = ST_RXPOLL;
                        end
                    end
                end
            end

            ST_DONE: begin
                gap_n   = 1'b0;
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign err        = err_q;
    assign resp_byte  = resp_byte_q;
    assign resp_valid = resp_valid_q;

    assign bus.m_chipselect_o = cs;
    assign bus.m_write_n_o    = wr_n;
    assign bus.m_read_n_o     = rd_n;
    assign bus.m_adr_o        = adr;
    assign bus.m_dat_o        = dat;

endmodule

`default_nettype wire
